// File: rtl/rs_inv_arbiter.sv
// rtl/rs_inv_arbiter.sv - round-robin arbiter feeding a two-stage GF(2^6) inverse pipeline
// Requesters share one inverter; S1 holds the operand, S2 holds the registered inverse.
module rs_inv_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               enable,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [6*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    output logic [5:0]         rsp_data,
    output logic [1:0]         rsp_id,
    output logic               rsp_zero,
    input  logic               rsp_ready,
    output logic [7:0]         zero_cnt,
    input  logic               zero_clr
);

    // Field polynomial x^6+x^5+x^4+x+1 with the x^6 term folded away.
    localparam logic [5:0] POLY_LO = 6'h33;

    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p;
        logic [5:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ x;
            x = x[5] ? ({x[4:0], 1'b0} ^ POLY_LO) : {x[4:0], 1'b0};
        end
        return p;
    endfunction

    // a^62 = a^-1 for nonzero a, and naturally maps 0 to 0.
    function automatic logic [5:0] gf_inv(input logic [5:0] a);
        logic [5:0] sq;
        logic [5:0] r;
        sq = a;
        r  = 6'd1;
        for (int i = 1; i < 6; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [5:0]       s1_op_q, s1_op_d;
    logic [1:0]       s1_id_q, s1_id_d;
    logic             s2_valid_q, s2_valid_d;
    logic [5:0]       s2_inv_q, s2_inv_d;
    logic [1:0]       s2_id_q, s2_id_d;
    logic             s2_zero_q, s2_zero_d;
    logic [1:0]       last_grant_q, last_grant_d;
    logic [7:0]       zero_cnt_q, zero_cnt_d;

    logic             s2_adv;
    logic             s1_can;
    logic             found;
    logic [1:0]       gidx;
    logic [N_REQ-1:0] grant;
    logic             transfer;
    logic [5:0]       gdata;

    always_comb begin
        s2_adv = enable && (!s2_valid_q || rsp_ready);
        s1_can = enable && (!s1_valid_q || s2_adv);
    end

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = idx[1:0];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found && s1_can) grant[gidx] = 1'b1;
        req_ready = grant & {N_REQ{RESET}};
        transfer  = |req_ready;
        gdata     = req_data[6*gidx +: 6];
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_id_d    = s1_id_q;
        if (s1_can) begin
            s1_valid_d = transfer;
            if (transfer) begin
                s1_op_d = gdata;
                s1_id_d = gidx;
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_inv_d   = s2_inv_q;
        s2_id_d    = s2_id_q;
        s2_zero_d  = s2_zero_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_inv_d  = gf_inv(s1_op_q);
                s2_id_d   = s1_id_q;
                s2_zero_d = (s1_op_q == 6'd0);
            end
        end
    end

    always_comb begin
        last_grant_d = transfer ? gidx : last_grant_q;
        zero_cnt_d   = zero_cnt_q;
        if (enable) begin
            if (zero_clr)
                zero_cnt_d = '0;
            else if (transfer && gdata == 6'd0 && zero_cnt_q != 8'hFF)
                zero_cnt_d = zero_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= '0;
            s1_id_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_inv_q     <= '0;
            s2_id_q      <= '0;
            s2_zero_q    <= 1'b0;
            last_grant_q <= 2'(N_REQ - 1);
            zero_cnt_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_id_q      <= s1_id_d;
            s2_valid_q   <= s2_valid_d;
            s2_inv_q     <= s2_inv_d;
            s2_id_q      <= s2_id_d;
            s2_zero_q    <= s2_zero_d;
            last_grant_q <= last_grant_d;
            zero_cnt_q   <= zero_cnt_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_data  = s2_inv_q;
    assign rsp_id    = s2_id_q;
    assign rsp_zero  = s2_zero_q;
    assign zero_cnt  = zero_cnt_q;

endmodule
